sbentsrc_health_packer: RTL
===========================

// Module: sbentsrc_health_packer
// PURPOSE
//  Downstream stage of the S-box entropy source: takes its registered RNG_WIDTH-bit raw
//  sample each i_clk, runs continuous health tests (repetition count, adaptive proportion),
//  discards a start-up block and packs surviving samples into OUT_WIDTH words.
//  Words leave on a valid/ready interface to the conditioner/FIFO.
//  Any health-test failure latches an alarm and stops output until reset.
// PARAMETERS
//  RNG_WIDTH     4   raw sample width; matches the entropy source output
//  OUT_WIDTH     32  packed word width; integer multiple of RNG_WIDTH
//  RCT_CUTOFF    8   consecutive identical samples that flag RCT failure (>=2)
//  APT_WINDOW    64  adaptive proportion window length, in samples
//  APT_CUTOFF    40  occurrences of window reference value that flag APT failure (<=APT_WINDOW)
//  STARTUP_WORDS 4   packed words discarded after each enable before output begins
// PORTS
//  i_clk       in   1          single clock; source sampler runs on the same clock
//  i_reset     in   1          asynchronous, active-high reset
//  i_en        in   1          1 = consume one sample per clock; 0 = idle
//  i_rnd       in   RNG_WIDTH  raw sample from entropy source (already registered)
//  o_data      out  OUT_WIDTH  packed word; valid while o_valid=1
//  o_valid     out  1          word available
//  i_ready     in   1          consumer accepts word when o_valid & i_ready at posedge
//  o_overflow  out  1          1-cycle pulse: completed word dropped (output register full)
//  o_rct_fail  out  1          sticky RCT failure flag
//  o_apt_fail  out  1          sticky APT failure flag
//  o_alarm     out  1          = o_rct_fail | o_apt_fail (registered)
// BEHAVIOUR
//  Reset (async, i_reset=1): state IDLE; all outputs 0; shift reg, counters, refs cleared.
//  States: IDLE -> STARTUP (i_en=1) -> RUN (after STARTUP_WORDS words); any -> ALARM on fail.
//   STARTUP/RUN -> IDLE when i_en=0 (sample that cycle not consumed); ALARM left only by reset.
//   STARTUP_WORDS=0: IDLE goes directly to RUN.
//  Sample consumption: every posedge with state in {STARTUP,RUN} and i_en=1.
//  RCT: first sample after IDLE loads ref, count=1. Equal sample -> count+1 (saturate at
//   RCT_CUTOFF); different -> ref=sample, count=1. count reaching RCT_CUTOFF sets o_rct_fail.
//  APT: first sample of each window is ref, cnt=1, idx=1. Each further sample idx+1, cnt+1 if
//   equal to ref. cnt reaching APT_CUTOFF sets o_apt_fail. After sample APT_WINDOW the next
//   consumed sample starts a new window. Leaving to IDLE aborts window; RCT/APT restart fresh.
//  Fail flags set on the posedge consuming the failing sample; o_alarm and state ALARM same edge.
//  Packing: {shift, i_rnd} shifted in at LSB; K=OUT_WIDTH/RNG_WIDTH samples form a word, first
//   sample in MSBs. Word complete on edge consuming Kth sample; pack count wraps to 0.
//   Partial word discarded on entry to IDLE or ALARM.
//  STARTUP: completed words counted and discarded, never presented.
//  RUN: completed word loads o_data/o_valid=1 on the same edge if o_valid=0 or (o_valid&i_ready);
//   else word dropped, o_overflow=1 for the next cycle. Latency: Kth sample edge -> o_valid high.
//  Handshake: o_data stable while o_valid&~i_ready; transfer clears o_valid unless refilled.
//   Pending word survives RUN->IDLE and is still delivered.
//  ALARM: o_valid and o_data forced to 0 on entry edge (pending word discarded); i_rnd ignored.
//  Simultaneous fail and word completion: fail wins, word not presented.
// TESTING
//  1. Reset mid-word (i_rnd counting 0..F, RUN) -> all outputs 0 immediately; re-enable needs 4
//     discarded words; first valid word = samples 32..39 packed, e.g. 0x0123_4567.
//  2. Counting pattern, i_ready=1, defaults -> first o_valid 40 cycles after i_en rises; one
//     word every 8 cycles, no alarm, o_overflow never set.
//  3. i_rnd held at 0x5 after 3 varied samples -> o_rct_fail=1, o_alarm=1 on 8th consecutive 0x5;
//     o_valid=0 next cycle; flags hold until i_reset.
//  4. Window with ref 0xA on 40 of 64 samples, never 8 in a row -> o_apt_fail at 40th 0xA;
//     39 occurrences -> no fail, new window starts at sample 65.
//  5. i_ready=0 in RUN -> first word held stable; 8 samples later o_overflow pulses once per
//     dropped word; raising i_ready delivers original word, next completed word follows.
//  6. i_en low mid-word with pending word -> pending word delivered, partial discarded;
//     re-enable restarts STARTUP (4 words) and RCT/APT counters.

Source files
------------

// File: rtl/sbentsrc_health_packer.sv
// rtl/sbentsrc_health_packer.sv - entropy source health tests and word packer
//
// Runs repetition-count and adaptive-proportion health tests on each consumed
// raw sample, discards a start-up block of packed words, then presents packed
// words on a valid/ready interface. Any health failure latches an alarm that
// only reset clears.
//
// Ports:
//   i_clk       clock
//   i_reset     asynchronous active-high reset
//   i_en        1 = consume one sample per clock
//   i_rnd       raw sample (RNG_WIDTH bits)
//   o_data      packed word (OUT_WIDTH bits), first sample in the MSBs
//   o_valid     word available
//   i_ready     consumer accepts the word when o_valid & i_ready
//   o_overflow  one-cycle pulse when a completed word had to be dropped
//   o_rct_fail  sticky repetition-count failure
//   o_apt_fail  sticky adaptive-proportion failure
//   o_alarm     registered OR of the two failure flags
module sbentsrc_health_packer #(
   parameter int RNG_WIDTH     = 4,
   parameter int OUT_WIDTH     = 32,
   parameter int RCT_CUTOFF    = 8,
   parameter int APT_WINDOW    = 64,
   parameter int APT_CUTOFF    = 40,
   parameter int STARTUP_WORDS = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_en,
   input  logic [RNG_WIDTH-1:0] i_rnd,
   output logic [OUT_WIDTH-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_overflow,
   output logic                 o_rct_fail,
   output logic                 o_apt_fail,
   output logic                 o_alarm
);

   localparam int K  = OUT_WIDTH / RNG_WIDTH;
   localparam int PW = (K > 1) ? $clog2(K) : 1;
   localparam int RW = $clog2(RCT_CUTOFF + 1);
   localparam int AW = $clog2(APT_WINDOW + 1);
   localparam int SW = (STARTUP_WORDS > 1) ? $clog2(STARTUP_WORDS) : 1;

   localparam logic [PW-1:0] PACK_LAST = PW'(K - 1);
   localparam logic [RW-1:0] RCT_MAX   = RW'(RCT_CUTOFF);
   localparam logic [AW-1:0] APT_WIN   = AW'(APT_WINDOW);
   localparam logic [AW-1:0] APT_CUT   = AW'(APT_CUTOFF);
   localparam logic [SW-1:0] SU_LAST   = SW'((STARTUP_WORDS > 0) ? STARTUP_WORDS - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_STARTUP, ST_RUN, ST_ALARM} state_t;

   state_t               state, state_n;
   logic [PW-1:0]        pack_cnt;
   logic [OUT_WIDTH-1:0] shift;
   logic [RNG_WIDTH-1:0] rct_ref, apt_ref;
   logic [RW-1:0]        rct_cnt, rct_cnt_n;
   logic [AW-1:0]        apt_cnt, apt_cnt_n, apt_idx;
   logic [SW-1:0]        su_cnt;
   logic                 consume, apt_new, rct_hit, apt_hit, fail, word_done;
   logic [OUT_WIDTH-1:0] word;

   always_comb begin
      consume   = ((state == ST_STARTUP) || (state == ST_RUN)) && i_en;
      // rct_cnt == 0 marks a fresh run after IDLE: the sample becomes the reference
      if ((rct_cnt == '0) || (i_rnd != rct_ref))
         rct_cnt_n = RW'(1);
      else if (rct_cnt == RCT_MAX)
         rct_cnt_n = rct_cnt;
      else
         rct_cnt_n = rct_cnt + RW'(1);
      // apt_idx == 0 after IDLE, == APT_WIN once a window has been filled
      apt_new   = (apt_idx == '0) || (apt_idx == APT_WIN);
      apt_cnt_n = apt_new ? AW'(1) : apt_cnt + AW'(i_rnd == apt_ref);
      rct_hit   = consume && (rct_cnt_n == RCT_MAX);
      apt_hit   = consume && (apt_cnt_n == APT_CUT);
      fail      = rct_hit || apt_hit;
      word_done = consume && (pack_cnt == PACK_LAST);
      word      = (shift << RNG_WIDTH) | OUT_WIDTH'(i_rnd);
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:    if (i_en) state_n = (STARTUP_WORDS == 0) ? ST_RUN : ST_STARTUP;
         ST_STARTUP: if (!i_en) state_n = ST_IDLE;
                     else if (fail) state_n = ST_ALARM;
                     else if (word_done && (su_cnt == SU_LAST)) state_n = ST_RUN;
         ST_RUN:     if (!i_en) state_n = ST_IDLE;
                     else if (fail) state_n = ST_ALARM;
         default:    state_n = ST_ALARM;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_n;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_overflow <= 1'b0;
         o_rct_fail <= 1'b0;
         o_apt_fail <= 1'b0;
         o_alarm    <= 1'b0;
         pack_cnt   <= '0;
         shift      <= '0;
         rct_ref    <= '0;
         rct_cnt    <= '0;
         apt_ref    <= '0;
         apt_cnt    <= '0;
         apt_idx    <= '0;
         su_cnt     <= '0;
      end else begin
         o_overflow <= 1'b0;
         if (state != ST_ALARM) begin
            if (fail) begin
               // failure beats a simultaneously completed word; pending word is discarded
               o_rct_fail <= o_rct_fail | rct_hit;
               o_apt_fail <= o_apt_fail | apt_hit;
               o_alarm    <= 1'b1;
               o_valid    <= 1'b0;
               o_data     <= '0;
               pack_cnt   <= '0;
               shift      <= '0;
            end else begin
               if (o_valid && i_ready) o_valid <= 1'b0;
               if (consume) begin
                  rct_ref <= i_rnd;
                  rct_cnt <= rct_cnt_n;
                  if (apt_new) apt_ref <= i_rnd;
                  apt_cnt <= apt_cnt_n;
                  apt_idx <= apt_new ? AW'(1) : apt_idx + AW'(1);
                  if (word_done) begin
                     pack_cnt <= '0;
                     shift    <= '0;
                     if (state == ST_STARTUP) begin
                        su_cnt <= su_cnt + SW'(1);
                     end else if (!o_valid || i_ready) begin
                        o_data  <= word;
                        o_valid <= 1'b1;
                     end else begin
                        o_overflow <= 1'b1;
                     end
                  end else begin
                     pack_cnt <= pack_cnt + PW'(1);
                     shift    <= word;
                  end
               end else begin
                  // idle or leaving to idle: partial word and health state restart fresh
                  pack_cnt <= '0;
                  shift    <= '0;
                  rct_cnt  <= '0;
                  apt_cnt  <= '0;
                  apt_idx  <= '0;
                  su_cnt   <= '0;
               end
            end
         end
      end
   end

endmodule
